// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV M funct3
// operation encodings, the handshake state encoding and small op decoders.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Divide/remainder group is funct3[2] = 1.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Remainder ops are 110/111.
    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed for these ops.
    function automatic logic op_a_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as signed for these ops.
    function automatic logic op_b_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide,
// one bit per cycle. One load cycle, then exactly XLEN iterations with the
// counter running 0..XLEN-1. The accumulator is 2*XLEN bits:
//   multiply: {partial product high, remaining multiplier bits}
//   divide:   {partial remainder, quotient bits}
module muldiv_core #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              loaded_q, loaded_d;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_trial_s;

    assign acc  = acc_q;
    assign last = run & loaded_q & (cnt_q == CW'(XLEN - 1));

    // Next-state for load / iterate / idle of the accumulator and counter.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
        div_trial_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
        if (!run) begin
            loaded_d = 1'b0;
            cnt_d    = {CW{1'b0}};
        end else if (!loaded_q) begin
            // Both operations start with the rs1 magnitude in the low half.
            loaded_d = 1'b1;
            cnt_d    = {CW{1'b0}};
            acc_d    = {{XLEN{1'b0}}, mag_a};
        end else begin
            cnt_d = last ? {CW{1'b0}} : cnt_q + CW'(1);
            if (is_div) begin
                if (!div_trial_s[XLEN]) begin
                    acc_d = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {(2*XLEN){1'b0}};
            cnt_q    <= {CW{1'b0}};
            loaded_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit with valid/ready handshakes. The
// handshake FSM and sign fixup live here; the iteration is in muldiv_core.
// Latency from accept edge to out_valid is xlen+2 cycles for every op:
// one magnitude load cycle, xlen iterations and one fixup cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [xlen-1:0] a,
    input  logic [xlen-1:0] b,
    input  logic [2:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [xlen-1:0] result,
    output logic            zero
);

    state_e            state_q, state_d;
    logic [xlen-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [xlen-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic              a_neg_s, b_neg_s;
    logic [xlen-1:0]   mag_a_s, mag_b_s;
    logic [2*xlen-1:0] acc_s;
    logic              last_s;
    logic [2*xlen-1:0] prod_s;
    logic [xlen-1:0]   quot_s, rem_s;
    logic [xlen-1:0]   fix_s;

    function automatic logic [xlen-1:0] neg_x(input logic [xlen-1:0] v);
        return ~v + {{(xlen-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*xlen-1:0] neg_2x(input logic [2*xlen-1:0] v);
        return ~v + {{(2*xlen-1){1'b0}}, 1'b1};
    endfunction

    assign a_neg_s = op_a_signed(op_q) & a_q[xlen-1];
    assign b_neg_s = op_b_signed(op_q) & b_q[xlen-1];
    assign mag_a_s = a_neg_s ? neg_x(a_q) : a_q;
    assign mag_b_s = b_neg_s ? neg_x(b_q) : b_q;

    muldiv_core #(.XLEN(xlen)) u_core (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == ST_BUSY),
        .is_div (op_is_div(op_q)),
        .mag_a  (mag_a_s),
        .mag_b  (mag_b_s),
        .acc    (acc_s),
        .last   (last_s)
    );

    // Sign correction and result selection from the finished accumulator.
    always_comb begin
        prod_s = (a_neg_s ^ b_neg_s) ? neg_2x(acc_s) : acc_s;
        quot_s = acc_s[xlen-1:0];
        rem_s  = acc_s[2*xlen-1:xlen];
        fix_s  = {xlen{1'b0}};
        if (!op_is_div(op_q)) begin
            if (op_q == OP_MUL) begin
                fix_s = prod_s[xlen-1:0];
            end else begin
                fix_s = prod_s[2*xlen-1:xlen];
            end
        end else if (b_q == {xlen{1'b0}}) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            if (op_is_rem(op_q)) begin
                fix_s = a_q;
            end else begin
                fix_s = {xlen{1'b1}};
            end
        end else if (op_is_rem(op_q)) begin
            fix_s = a_neg_s ? neg_x(rem_s) : rem_s;
        end else begin
            // Overflow (-2^(xlen-1) / -1) falls out naturally: the magnitude
            // 2^(xlen-1) is returned unnegated, which equals the dividend.
            fix_s = (a_neg_s ^ b_neg_s) ? neg_x(quot_s) : quot_s;
        end
    end

    // Handshake FSM next-state and registered output values.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_d = ST_FIXUP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FIXUP: begin
                result_d = fix_s;
                zero_d   = (fix_s == {xlen{1'b0}});
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and output registers; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {xlen{1'b0}};
            b_q         <= {xlen{1'b0}};
            op_q        <= 3'b000;
            result_q    <= {xlen{1'b0}};
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
